// File: rtl/divmod_unit.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// Define DIVMOD_EARLY_EXIT_EN to finish in one cycle when a < b.
module divmod_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;   // dividend shifts out MSB first, quotient bits shift in
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic             fits;

   always_comb begin
      rem_sh  = {rem_q, acc_q[WIDTH-1]};
      fits    = (rem_sh >= {1'b0, dvs_q});
      // True difference is below the divisor, so the low WIDTH bits are exact.
      rem_sub = rem_sh[WIDTH-1:0] - dvs_q;

      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = a;
               dvs_d = b;
               rem_d = '0;
               cnt_d = '0;
               if (b == '0) begin
                  dbz_d   = 1'b1;
                  quo_d   = '1;
                  rmd_d   = a;
                  state_d = DONE;
               end
`ifdef DIVMOD_EARLY_EXIT_EN
               else if (a < b) begin
                  dbz_d   = 1'b0;
                  quo_d   = '0;
                  rmd_d   = a;
                  state_d = DONE;
               end
`endif
               else begin
                  dbz_d   = 1'b0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = fits ? rem_sub : rem_sh[WIDTH-1:0];
            acc_d = {acc_q[WIDTH-2:0], fits};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               quo_d   = {acc_q[WIDTH-2:0], fits};
               rmd_d   = fits ? rem_sub : rem_sh[WIDTH-1:0];
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
endmodule

// File: tb/tb_divmod_unit.sv
// Directed bench for divmod_unit with a cycle-accurate reference model and per-cycle compare.
module tb_divmod_unit;
   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   divmod_unit #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .quotient(quotient), .remainder(remainder)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit           pend = 0;
   longint       acc_t = 0;
   int           lat = 0;
   logic [W-1:0] exp_q, exp_r, last_q = '0, last_r = '0;
   logic         exp_dbz, last_dbz = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_accept(input logic [W-1:0] ta, input logic [W-1:0] tb_);
      pend  = 1;
      acc_t = $time;
      if (tb_ == 0) begin
         exp_q = '1; exp_r = ta; exp_dbz = 1'b1; lat = 0;
      end else begin
         exp_q = ta / tb_; exp_r = ta % tb_; exp_dbz = 1'b0;
`ifdef DIVMOD_EARLY_EXIT_EN
         lat = (ta < tb_) ? 0 : W;
`else
         lat = W;
`endif
      end
      last_dbz = exp_dbz;
   endtask

   // Per-cycle compare against the model.
   always @(negedge CLK) begin
      if (RST) begin
         chk("reset_outs", {busy, done, div_by_zero, quotient, remainder} == '0, 1'b1);
      end else begin
         chk("busy_done_excl", busy & done, 1'b0);
         if (pend && ($time == acc_t + 10 * lat + 5)) begin
            chk("done_on_time", done, 1'b1);
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
            chk("div_by_zero", div_by_zero, exp_dbz);
            last_q = exp_q; last_r = exp_r;
            pend = 0;
         end else begin
            chk("done_low", done, 1'b0);
            chk("busy", busy, pend && lat != 0);
            chk("quotient_hold", quotient, last_q);
            chk("remainder_hold", remainder, last_r);
            chk("dbz_hold", div_by_zero, last_dbz);
            if (pend && ($time > acc_t + 10 * lat + 5)) begin
               errors++;
               $display("FAIL timeout: no done for op accepted at %0t", acc_t);
               pend = 0;
            end
         end
      end
   end

   task automatic wait_done(input bit toggle);
      for (int i = 0; i < 60 && pend; i++) begin
         @(posedge CLK); #1;
         if (toggle) begin a = $urandom; b = $urandom; end
      end
   endtask

   // Issue one operation; lq/lr are hand-computed values pinning the model.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] lq, input logic [W-1:0] lr, input bit wt);
      @(negedge CLK);
      start = 1'b1; a = ta; b = tb_;
      @(posedge CLK);
      model_accept(ta, tb_);
      chk("model_q_pin", exp_q, lq);
      chk("model_r_pin", exp_r, lr);
      #1 start = 1'b0; a = ~ta; b = ~tb_;
      if (wt) wait_done(1'b0);
   endtask

   task automatic pulse_reset();
      @(posedge CLK); #2;
      RST = 1'b1;
      pend = 0; last_q = '0; last_r = '0; last_dbz = 1'b0;
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      repeat (2) @(posedge CLK);

      do_op(32'd38, 32'd7, 32'd5, 32'd3, 1);
      do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1);
      do_op(32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1);
      do_op(32'd9, 32'd3, 32'd3, 32'd0, 1);
      do_op(32'd0, 32'd13, 32'd0, 32'd0, 1);
      do_op(32'd12345, 32'd12345, 32'd1, 32'd0, 1);
      do_op(32'd5, 32'd9, 32'd0, 32'd5, 1);
      do_op(32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD, 32'h0000_BEEF, 1);

      // reset in the middle of CALC aborts the operation
      do_op(32'd1000, 32'd7, 32'd142, 32'd6, 0);
      repeat (9) @(posedge CLK);
      pulse_reset();
      repeat (2) @(posedge CLK);
      do_op(32'd38, 32'd7, 32'd5, 32'd3, 1);

      // start held high with operands changing during CALC
      @(negedge CLK);
      start = 1'b1; a = 32'd77; b = 32'd10;
      @(posedge CLK);
      model_accept(32'd77, 32'd10);
      chk("model_q_pin", exp_q, 32'd7);
      #1 wait_done(1'b1);
      a = 32'd20; b = 32'd6;
      @(posedge CLK);
      model_accept(32'd20, 32'd6);
      chk("model_r_pin", exp_r, 32'd2);
      #1 start = 1'b0;
      wait_done(1'b0);

      repeat (3) @(posedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/divmod_unit.md
DIVMOD_UNIT -- requirements
Module: divmod_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand, quotient and remainder width (legal range 4..64).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned dividend, captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned divisor, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in CALC.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse, high while in DONE.
REQ-009 The block SHALL have port div_by_zero, output, 1 bit: the last accepted operation had b == 0.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: the last result.
REQ-011 The block SHALL have port remainder, output, WIDTH bits: the last result.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; IDLE->CALC on start; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally after one cycle.
REQ-013 CALC SHALL perform restoring shift-subtract division, one quotient bit per cycle, MSB first, using a WIDTH+1-bit partial remainder so that no borrow is lost.
REQ-014 For a start accepted at edge N with b != 0, done SHALL be high in the cycle following edge N+WIDTH, with quotient = a/b and remainder = a mod b.
REQ-015 If b == 0 on the accepting edge, the FSM SHALL go directly to DONE, with div_by_zero=1, quotient = all ones and remainder = a, so that done is high one cycle after acceptance.
REQ-016 div_by_zero SHALL be cleared on the next accepted start.
REQ-017 start SHALL be ignored in CALC and DONE, and a and b changes after acceptance SHALL NOT affect the result.
REQ-018 quotient and remainder SHALL hold their last values from DONE until the next result is written; intermediate values SHALL NOT be visible on these outputs.
REQ-019 busy and done SHALL never be high simultaneously.
REQ-020 a == 0 with b != 0 SHALL yield quotient 0 and remainder 0 (with full latency unless REQ-025 applies); a == b SHALL yield quotient 1 and remainder 0.

Reset
REQ-021 RST high SHALL immediately force state IDLE and all outputs low: busy, done, div_by_zero, quotient and remainder all 0.
REQ-022 RST asserted mid-CALC SHALL abort the operation with no done pulse; after release, the first start SHALL behave as from power-up.
REQ-023 The iteration counter and internal operand registers SHALL reset to 0.

Configuration
REQ-024 Macro DIVMOD_EARLY_EXIT_EN SHALL select the early-exit feature.
REQ-025 With DIVMOD_EARLY_EXIT_EN defined, an accepted start with b != 0 and a < b (unsigned) SHALL go directly to DONE with quotient 0 and remainder a, so that done is high one cycle after acceptance.
REQ-026 Without DIVMOD_EARLY_EXIT_EN, every b != 0 operation SHALL take the full WIDTH-cycle latency; results SHALL be identical in both builds.

Verification
REQ-027 Scenario: WIDTH=32, a=38, b=7, start at edge 0 -> busy for 32 cycles; done pulse one cycle after edge 32; quotient=5, remainder=3.
REQ-028 Scenario: a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0; a=0x80000000, b=0xFFFFFFFF -> quotient=0, remainder=0x80000000.
REQ-029 Scenario: a=100, b=0 -> done one cycle after accept; div_by_zero=1, quotient=0xFFFFFFFF, remainder=100; the next start with a=9, b=3 clears the flag and gives quotient 3, remainder 0.
REQ-030 Scenario: RST pulsed at cycle 10 of CALC -> no done pulse, all outputs 0; a new start with a=38, b=7 then completes correctly.
REQ-031 Scenario: start held high and a/b toggled during CALC -> one result only, for the captured operands; after done, start re-accepted in IDLE.
REQ-032 Scenario: a=5, b=9 -> with DIVMOD_EARLY_EXIT_EN, done one cycle after accept; without it, done after 32 cycles; in both builds quotient=0, remainder=5.
